// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and encodings for the pipeline hazard logic:
//                controller state enum, forwarding-select codes and the
//                operand forwarding select function.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Hazard controller states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // ALU operand source select encodings
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int STALL_W = 16;

    // The youngest producer wins: EX/MEM result before MEM/WB result.
    function automatic logic [1:0] fwd_select(
        input logic [3:0] rs,
        input logic       mem_wbs,
        input logic [3:0] mem_rd,
        input logic       wb_wbs,
        input logic [3:0] wb_rd
    );
        if (mem_wbs && (mem_rd == rs))
            return FWD_EXMEM;
        else if (wb_wbs && (wb_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit
//  Description : Purely combinational operand forwarding selects for both
//                ALU operands of the instruction in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarding_unit
    import cpu_pkg::*;
(
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic       mem_wbs,
    input  logic [3:0] mem_rd,
    input  logic       wb_wbs,
    input  logic [3:0] wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Same select rule applied to each source operand
    always_comb begin
        fwd_a = fwd_select(rs1, mem_wbs, mem_rd, wb_wbs, wb_rd);
        fwd_b = fwd_select(rs2, mem_wbs, mem_rd, wb_wbs, wb_rd);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Five-stage pipeline hazard control: data-memory stall FSM,
//                branch flush, load-use stall, operand forwarding and a
//                saturating stall-cycle performance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           id_rs1,
    input  logic [3:0]           id_rs2,
    input  logic                 id_uses_rs2,
    input  logic [3:0]           ex_rd,
    input  logic                 ex_wbs,
    input  logic                 ex_mm,
    input  logic [3:0]           mem_rd,
    input  logic                 mem_wbs,
    input  logic                 mem_mm,
    input  logic                 mem_wme,
    input  logic [3:0]           wb_rd,
    input  logic                 wb_wbs,
    input  logic                 branch_taken,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    input  logic                 stat_clr,
    output logic [STALL_W-1:0]   stall_cycles
);

    hz_state_t           r_state;
    hz_state_t           w_next_state;
    logic                r_mem_req;
    logic [STALL_W-1:0]  r_stall_cycles;
    logic                w_load_use;
    logic                w_mem_op;

    assign w_mem_op   = mem_mm | mem_wme;
    assign w_load_use = ex_mm & ex_wbs &
                        ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // Mealy enables/flushes: memory stall freezes everything; once memory is
    // done (or not involved) branch flush beats load-use, which beats normal.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        w_next_state = RUN;
        if ((r_state == RUN && w_mem_op) || (r_state == MEM_WAIT && !mem_ack)) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            w_next_state = MEM_WAIT;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_load_use) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    // State register with registered memory request (high throughout MEM_WAIT)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_mem_req <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_mem_req <= (w_next_state == MEM_WAIT);
        end
    end

    // Saturating count of frozen-PC cycles; clear has priority over count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cycles <= '0;
        else if (stat_clr)
            r_stall_cycles <= '0;
        else if (!pc_en && (r_stall_cycles != {STALL_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign mem_req      = r_mem_req;
    assign stall_cycles = r_stall_cycles;

    forwarding_unit u_fwd (
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .mem_wbs (mem_wbs),
        .mem_rd  (mem_rd),
        .wb_wbs  (wb_wbs),
        .wb_rd   (wb_rd),
        .fwd_a   (fwd_a),
        .fwd_b   (fwd_b)
    );

endmodule
`default_nettype wire
